// File: rtl/keypad_entry_decoder.sv
// keypad_entry_decoder: synchronises and debounces the keypad {code, valid} stream,
// assembles a PIN entry buffer and hands it to the lock FSM over valid/ready.
module keypad_entry_decoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PIN_DIGITS      = 4,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              code,
   input  logic                    valid,
   output logic                    key_event,
   output logic [3:0]              key_code,
   output logic [4*PIN_DIGITS-1:0] digits,
   output logic [3:0]              digit_count,
   output logic                    entry_valid,
   input  logic                    entry_ready,
   output logic                    entry_cleared,
   output logic                    overflow,
   output logic                    timeout
);
   typedef enum logic {COLLECT, HOLD} state_t;
   state_t                  state_q, state_d;
   logic [4:0]              sync1_q, sync2_q, sample;
   logic [4:0]              cand_q, cand_d, acc_q, acc_d;
   logic [15:0]             deb_q, deb_d;
   logic [31:0]             idle_q, idle_d;
   logic [4*PIN_DIGITS-1:0] digits_q, digits_d;
   logic [3:0]              count_q, count_d, key_code_q;
   logic                    key_event_q, cleared_q, cleared_d, overflow_q, overflow_d;
   logic                    timeout_q, timeout_d, press, idle_hit;
   // code is don't-care while released, so mask it to keep code noise from restarting the debounce
   assign sample = sync2_q[4] ? sync2_q : 5'd0;
   // the reloading sample counts as the first of the DEBOUNCE_CYCLES identical samples
   always_comb begin
      cand_d = cand_q;
      deb_d  = deb_q;
      if (sample != cand_q) begin
         cand_d = sample;
         deb_d  = 16'd1;
      end else if (deb_q < 16'(DEBOUNCE_CYCLES)) begin
         deb_d = deb_q + 16'd1;
      end
      acc_d = (deb_d == 16'(DEBOUNCE_CYCLES)) ? cand_d : acc_q;
   end
   assign press    = !acc_q[4] && acc_d[4] && (acc_d[3:0] < 4'd12);
   assign idle_hit = (TIMEOUT_CYCLES != 0) && (state_q == COLLECT) && (count_q != 4'd0) &&
                     (idle_q == 32'(TIMEOUT_CYCLES - 1));
   always_comb begin
      state_d    = state_q;
      digits_d   = digits_q;
      count_d    = count_q;
      cleared_d  = 1'b0;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
      idle_d     = (press || state_q != COLLECT || count_q == 4'd0) ? 32'd0 : idle_q + 32'd1;
      if (state_q == HOLD) begin
         if (entry_ready) begin
            state_d  = COLLECT;
            digits_d = '0;
            count_d  = 4'd0;
         end
      end else if (press) begin
         if (acc_d[3:0] < 4'd10) begin
            if (count_q < 4'(PIN_DIGITS)) begin
               for (int i = 0; i < PIN_DIGITS; i++)
                  if (4'(i) == count_q) digits_d[4*i +: 4] = acc_d[3:0];
               count_d = count_q + 4'd1;
            end else begin
               overflow_d = 1'b1;
            end
         end else if (acc_d[3:0] == 4'd10) begin
            digits_d  = '0;
            count_d   = 4'd0;
            cleared_d = 1'b1;
         end else if (count_q != 4'd0) begin
            state_d = HOLD;
         end
      end else if (idle_hit) begin
         digits_d  = '0;
         count_d   = 4'd0;
         timeout_d = 1'b1;
         idle_d    = 32'd0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         sync1_q     <= 5'd0;
         sync2_q     <= 5'd0;
         cand_q      <= 5'd0;
         acc_q       <= 5'd0;
         deb_q       <= 16'd0;
         idle_q      <= 32'd0;
         digits_q    <= '0;
         count_q     <= 4'd0;
         key_code_q  <= 4'd0;
         key_event_q <= 1'b0;
         cleared_q   <= 1'b0;
         overflow_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= {valid, code};
         sync2_q     <= sync1_q;
         cand_q      <= cand_d;
         acc_q       <= acc_d;
         deb_q       <= deb_d;
         idle_q      <= idle_d;
         digits_q    <= digits_d;
         count_q     <= count_d;
         key_code_q  <= press ? acc_d[3:0] : key_code_q;
         key_event_q <= press;
         cleared_q   <= cleared_d;
         overflow_q  <= overflow_d;
         timeout_q   <= timeout_d;
      end
   end
   assign key_event     = key_event_q;
   assign key_code      = key_code_q;
   assign digits        = digits_q;
   assign digit_count   = count_q;
   assign entry_valid   = (state_q == HOLD);
   assign entry_cleared = cleared_q;
   assign overflow      = overflow_q;
   assign timeout       = timeout_q;
endmodule

// File: tb/tb_keypad_entry_decoder.sv
// tb_keypad_entry_decoder: directed bench for keypad_entry_decoder with a 50-cycle idle timeout.
module tb_keypad_entry_decoder;
   logic        clk = 1'b0, rst_n, valid, entry_ready;
   logic [3:0]  code;
   logic        key_event, entry_valid, entry_cleared, overflow, timeout;
   logic [3:0]  key_code, digit_count;
   logic [15:0] digits;
   logic [28:0] outs;
   int n_tests = 0, n_fail = 0;
   int ev_n = 0, clr_n = 0, ovf_n = 0, to_n = 0;
   int lat, snap, first, ev1, ev2, ev_at, to_at;

   keypad_entry_decoder #(.DEBOUNCE_CYCLES(4), .PIN_DIGITS(4), .TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .rst_n(rst_n), .code(code), .valid(valid),
      .key_event(key_event), .key_code(key_code), .digits(digits), .digit_count(digit_count),
      .entry_valid(entry_valid), .entry_ready(entry_ready), .entry_cleared(entry_cleared),
      .overflow(overflow), .timeout(timeout)
   );

   assign outs = {key_event, key_code, digits, digit_count, entry_valid, entry_cleared, overflow, timeout};
   always #5 clk = ~clk;

   always @(negedge clk) begin
      ev_n  <= ev_n + int'(key_event);
      clr_n <= clr_n + int'(entry_cleared);
      ovf_n <= ovf_n + int'(overflow);
      to_n  <= to_n + int'(timeout);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // hold a key for `hold` cycles then release for 8; lat is the cycle key_event was seen (-1 if none)
   task automatic press(input logic [3:0] c, input int hold, output int l);
      code  = c;
      valid = 1'b1;
      l     = -1;
      for (int i = 1; i <= hold; i++) begin
         tick();
         if (key_event && l < 0) l = i;
      end
      valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
   endtask

   initial begin
      rst_n = 1'b0; code = 4'd0; valid = 1'b0; entry_ready = 1'b0;
      tick(); tick();
      check("rst_outputs", 32'(outs), 32'd0);
      rst_n = 1'b1;
      tick(); tick();
      check("rst_after_release", 32'(outs), 32'd0);

      // T1: single press latency and decode
      snap = ev_n; first = -1;
      code = 4'd5; valid = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (key_event && first < 0) first = i;
      end
      valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("t1_latency", 32'(first), 32'd6);
      check("t1_one_event", 32'(ev_n - snap), 32'd1);
      check("t1_key_code", 32'(key_code), 32'd5);
      check("t1_digits", 32'(digits), 32'h0005);
      check("t1_count", 32'(digit_count), 32'd1);
      snap = clr_n;
      press(4'd10, 8, lat);
      check("t1_clear_pulse", 32'(clr_n - snap), 32'd1);
      check("t1_clear_count", 32'(digit_count), 32'd0);

      // T2: 3-cycle glitch is rejected, bounce then stable is one event
      snap = ev_n;
      code = 4'd3; valid = 1'b1;
      tick(); tick(); tick();
      valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("t2_glitch_no_event", 32'(ev_n - snap), 32'd0);
      valid = 1'b1; tick(); tick();
      valid = 1'b0; tick();
      valid = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("t2_bounce_one_event", 32'(ev_n - snap), 32'd1);
      check("t2_digits", 32'(digits), 32'h0003);
      press(4'd10, 8, lat);

      // T3: fill, overflow, submit, hold, handshake
      press(4'd1, 8, lat); press(4'd2, 8, lat); press(4'd3, 8, lat); press(4'd4, 8, lat);
      check("t3_full_count", 32'(digit_count), 32'd4);
      snap = ovf_n;
      press(4'd5, 8, lat);
      check("t3_overflow", 32'(ovf_n - snap), 32'd1);
      check("t3_digits", 32'(digits), 32'h4321);
      press(4'd11, 8, lat);
      check("t3_entry_valid", 32'(entry_valid), 32'd1);
      snap = ovf_n;
      press(4'd7, 8, lat);
      for (int i = 0; i < 4; i++) tick();
      check("t3_hold_event_lat", 32'(lat), 32'd6);
      check("t3_hold_key_code", 32'(key_code), 32'd7);
      check("t3_hold_no_ovf", 32'(ovf_n - snap), 32'd0);
      check("t3_hold_frozen", {15'd0, entry_valid, digit_count, digits[11:0]}, {15'd0, 1'b1, 4'd4, 12'h321});
      check("t3_hold_digits", 32'(digits), 32'h4321);
      entry_ready = 1'b1;
      tick();
      entry_ready = 1'b0;
      check("t3_handshake_ev", 32'(entry_valid), 32'd0);
      check("t3_handshake_buf", {12'd0, digit_count, digits}, 32'd0);

      // T4: clear, empty submit, clear on empty, unused codes
      press(4'd7, 8, lat); press(4'd8, 8, lat);
      check("t4_digits", 32'(digits), 32'h0087);
      snap = clr_n;
      press(4'd10, 8, lat);
      check("t4_cleared", 32'(clr_n - snap), 32'd1);
      check("t4_buf_zero", {12'd0, digit_count, digits}, 32'd0);
      press(4'd11, 8, lat);
      check("t4_empty_submit", 32'(entry_valid), 32'd0);
      snap = clr_n;
      press(4'd10, 8, lat);
      check("t4_clear_empty", 32'(clr_n - snap), 32'd1);
      snap = ev_n;
      press(4'd13, 8, lat);
      check("t4_code13_no_event", 32'(ev_n - snap), 32'd0);

      // T5: idle timeout 50 cycles after the event; a press on the timeout edge wins
      ev_at = -1; to_at = -1;
      code = 4'd9; valid = 1'b1;
      for (int i = 1; i <= 80; i++) begin
         tick();
         if (key_event && ev_at < 0) ev_at = i;
         if (timeout && to_at < 0) to_at = i;
         if (i == 8) valid = 1'b0;
      end
      check("t5_timeout_delay", 32'(to_at - ev_at), 32'd50);
      check("t5_timeout_count", 32'(digit_count), 32'd0);
      snap = to_n; ev1 = -1; ev2 = -1;
      code = 4'd1; valid = 1'b1;
      for (int i = 1; i <= 75; i++) begin
         tick();
         if (key_event && ev1 > 0 && ev2 < 0) ev2 = i;
         if (key_event && ev1 < 0) ev1 = i;
         if (i == 8) valid = 1'b0;
         if (ev1 > 0 && i == ev1 + 44) begin code = 4'd2; valid = 1'b1; end
         if (ev1 > 0 && i == ev1 + 52) valid = 1'b0;
      end
      check("t5_press_on_edge", 32'(ev2 - ev1), 32'd50);
      check("t5_no_timeout", 32'(to_n - snap), 32'd0);
      check("t5_count2", 32'(digit_count), 32'd2);
      check("t5_digits", 32'(digits), 32'h0021);
      press(4'd10, 8, lat);

      // T6: asynchronous reset mid-HOLD and mid-debounce
      press(4'd4, 8, lat); press(4'd11, 8, lat);
      check("t6_in_hold", 32'(entry_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_reset_hold", 32'(outs), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      code = 4'd6; valid = 1'b1;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check("t6_reset_debounce", 32'(outs), 32'd0);
      tick();
      rst_n = 1'b1;
      first = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (key_event && first < 0) first = i;
      end
      valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("t6_latency", 32'(first), 32'd6);
      check("t6_key_code", 32'(key_code), 32'd6);
      check("t6_count", 32'(digit_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
